// File: rtl/sync_data_fifo.sv
// Single-clock elastic FIFO: one-hot read/write pointers over a register array,
// valid/ready on both sides, occupancy and programmable almost-full/empty flags.
module sync_data_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int BUFFER_DEPTH    = 8,
  parameter bit FALL_THROUGH    = 1'b0,
  parameter int ALMOST_FULL_TH  = BUFFER_DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     count,
  output logic                                  almost_full,
  output logic                                  almost_empty
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int IDX_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(ALMOST_EMPTY_TH);
  localparam logic [BUFFER_DEPTH-1:0] PTR_INIT = BUFFER_DEPTH'(1);

  logic [DATA_WIDTH-1:0]   mem [BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] wr_ptr;
  logic [BUFFER_DEPTH-1:0] rd_ptr;
  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        rd_idx;
  logic [CNT_W-1:0]        count_q;
  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    bypass;
  logic                    wr_en;
  logic                    rd_en;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [BUFFER_DEPTH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [BUFFER_DEPTH-1:0] rotl(input logic [BUFFER_DEPTH-1:0] p);
    return {p[BUFFER_DEPTH-2:0], p[BUFFER_DEPTH-1]};
  endfunction

  assign wr_idx = onehot_to_idx(wr_ptr);
  assign rd_idx = onehot_to_idx(rd_ptr);

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // Handshake: a word moves on a side only in a cycle where valid and ready are
  // both high at the rising edge. in_ready depends on registered occupancy only,
  // so a full FIFO refuses a push even while it is being popped.
  assign in_ready  = ~full;
  assign out_valid = ~empty | (FALL_THROUGH & in_valid);
  assign out_data  = (FALL_THROUGH && empty) ? in_data : mem[rd_idx];

  assign push   = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  // Word passes straight through an empty fall-through FIFO without touching storage.
  assign bypass = FALL_THROUGH & empty & push & pop;
  assign wr_en  = push & ~bypass & ~flush;
  assign rd_en  = pop & ~bypass & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= PTR_INIT;
      rd_ptr <= PTR_INIT;
    end else if (flush) begin
      wr_ptr <= PTR_INIT;
      rd_ptr <= PTR_INIT;
    end else begin
      if (wr_en) wr_ptr <= rotl(wr_ptr);
      if (rd_en) rd_ptr <= rotl(rd_ptr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
  a_wr_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot(wr_ptr));
  a_rd_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot(rd_ptr));

endmodule
